// File: rtl/dmem_pkg.sv
// Shared types and lane helpers for the big-endian data memory.
// Byte lane masks use bit 3 for byte offset 0 (bits [31:24]) and bit 0 for offset 3.
package dmem_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE    = 2'b00,
        SIZE_HALF    = 2'b01,
        SIZE_WORD    = 2'b10,
        SIZE_ILLEGAL = 2'b11
    } size_e;

    typedef enum logic {
        IDLE  = 1'b0,
        SPLIT = 1'b1
    } state_e;

    function automatic logic [3:0] base_mask(input size_e size);
        case (size)
            SIZE_BYTE: return 4'b1000;
            SIZE_HALF: return 4'b1100;
            SIZE_WORD: return 4'b1111;
            default:   return 4'b0000;
        endcase
    endfunction

    // Lanes touched in the word holding the start address.
    function automatic logic [3:0] lane_mask(input logic [1:0] offset, input size_e size);
        return base_mask(size) >> offset;
    endfunction

    // Lanes that spill into the following word.
    function automatic logic [3:0] spill_mask(input logic [1:0] offset, input size_e size);
        return 4'(({base_mask(size), 4'b0000} >> offset));
    endfunction

    function automatic logic [1:0] last_offset(input size_e size);
        case (size)
            SIZE_HALF: return 2'd1;
            SIZE_WORD: return 2'd3;
            default:   return 2'd0;
        endcase
    endfunction

    function automatic logic [31:0] store_left(input logic [31:0] wdata, input size_e size);
        case (size)
            SIZE_BYTE: return {wdata[7:0], 24'h0};
            SIZE_HALF: return {wdata[15:0], 16'h0};
            default:   return wdata;
        endcase
    endfunction

    function automatic logic [31:0] store_beat1(input logic [31:0] wdata, input size_e size,
                                                input logic [1:0] offset);
        return 32'(({store_left(wdata, size), 32'h0} >> {offset, 3'b000}) >> 32);
    endfunction

    function automatic logic [31:0] store_beat2(input logic [31:0] wdata, input size_e size,
                                                input logic [1:0] offset);
        return 32'(({store_left(wdata, size), 32'h0} >> {offset, 3'b000}));
    endfunction

    // Bytes from the start offset onward, left-aligned, taken across two consecutive words.
    function automatic logic [31:0] merge_left(input logic [31:0] hi, input logic [31:0] lo,
                                               input logic [1:0] offset);
        return 32'(({hi, lo} << {offset, 3'b000}) >> 32);
    endfunction

    function automatic logic [31:0] load_align(input logic [31:0] left, input size_e size,
                                               input logic is_unsigned);
        case (size)
            SIZE_BYTE: return is_unsigned ? {24'h0, left[31:24]} : {{24{left[31]}}, left[31:24]};
            SIZE_HALF: return is_unsigned ? {16'h0, left[31:16]} : {{16{left[31]}}, left[31:16]};
            default:   return left;
        endcase
    endfunction

endpackage

// File: rtl/dmem_bank.sv
// Four byte-wide storage banks sharing one word address, with per-lane write enable and registered read.
module dmem_bank #(
    parameter int DEPTH_WORDS = 256
) (
    input  logic                           clk,
    input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
    input  logic [3:0]                     we,
    input  logic                           re,
    input  logic [31:0]                    wdata,
    output logic [31:0]                    rdata
);

    for (genvar lane = 0; lane < 4; lane++) begin : g_lane
        logic [7:0] mem [DEPTH_WORDS];
        logic [7:0] q;

        // NOTE: the array has no reset branch; a reset would turn it into flops instead of RAM.
        always_ff @(posedge clk) begin
            if (we[lane]) mem[addr] <= wdata[8*lane +: 8];
            if (re)       q         <= mem[addr];
        end

        assign rdata[8*lane +: 8] = q;
    end

endmodule

// File: rtl/data_memory_unit.sv
// Byte-addressable big-endian data memory with a valid/ready request port and fault detection.
// Define DMEM_MISALIGN_SPLIT_EN to execute misaligned half/word accesses as two aligned beats.
module data_memory_unit
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_fault
);

    localparam int ADDR_LSB_W = $clog2(DEPTH_WORDS) + 2;
    localparam int WORD_W     = ADDR_LSB_W - 2;

    size_e               size;
    logic [1:0]          offset;
    logic [WORD_W-1:0]   word_idx;
    logic [ADDR_LSB_W:0] last_byte;
    logic                illegal, out_of_range, misaligned, fault, accept, respond;
    logic [WORD_W-1:0]   bank_addr;
    logic [3:0]          bank_we;
    logic                bank_re;
    logic [31:0]         bank_wdata, bank_rdata, beat1_word, fresh_rdata, rdata_q;
    size_e               rsp_size;
    logic [1:0]          rsp_offset;
    logic                rsp_unsigned, rsp_load;

    assign size         = size_e'(req_size);
    assign offset       = req_addr[1:0];
    assign word_idx     = req_addr[ADDR_LSB_W-1:2];
    assign illegal      = (size == SIZE_ILLEGAL);
    assign last_byte    = {1'b0, req_addr[ADDR_LSB_W-1:0]} + (ADDR_LSB_W+1)'(last_offset(size));
    assign out_of_range = (|req_addr[31:ADDR_LSB_W]) || last_byte[ADDR_LSB_W];
    assign misaligned   = (size == SIZE_HALF && offset[0]) || (size == SIZE_WORD && offset != 2'b00);
    assign accept       = req_valid && req_ready;

`ifdef DMEM_MISALIGN_SPLIT_EN
    state_e            state;
    logic              split_write, rsp_split;
    logic [WORD_W-1:0] split_addr;
    logic [3:0]        split_be;
    logic [31:0]       split_wdata, beat1_q;

    assign req_ready = !rst && (state == IDLE);
    assign fault     = illegal || out_of_range;
    assign respond   = (accept && !(misaligned && !fault)) || (state == SPLIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                 state <= IDLE;
        else if (state == SPLIT)                 state <= IDLE;
        else if (accept && misaligned && !fault) state <= SPLIT;
    end

    // Beat-2 context is captured at accept; beat-1 read data is parked while beat 2 is read.
    always_ff @(posedge clk) begin
        if (accept) begin
            split_addr  <= word_idx + WORD_W'(1);
            split_be    <= spill_mask(offset, size);
            split_wdata <= store_beat2(req_wdata, size, offset);
            split_write <= req_write;
            rsp_split   <= misaligned && !fault;
        end
        if (state == SPLIT) beat1_q <= bank_rdata;
    end

    // NOTE: every branch assigns every output, so this block cannot infer a latch.
    always_comb begin
        if (state == SPLIT) begin
            bank_addr  = split_addr;
            bank_we    = split_write ? split_be : 4'b0000;
            bank_re    = !split_write;
            bank_wdata = split_wdata;
        end else begin
            bank_addr  = word_idx;
            bank_we    = (accept && req_write && !fault) ? lane_mask(offset, size) : 4'b0000;
            bank_re    = accept && !req_write && !fault;
            bank_wdata = store_beat1(req_wdata, size, offset);
        end
    end

    assign beat1_word = rsp_split ? beat1_q : bank_rdata;
`else
    assign req_ready  = !rst;
    assign fault      = illegal || out_of_range || misaligned;
    assign respond    = accept;
    assign bank_addr  = word_idx;
    assign bank_we    = (accept && req_write && !fault) ? lane_mask(offset, size) : 4'b0000;
    assign bank_re    = accept && !req_write && !fault;
    assign bank_wdata = store_beat1(req_wdata, size, offset);
    assign beat1_word = bank_rdata;
`endif

    dmem_bank #(.DEPTH_WORDS(DEPTH_WORDS)) u_bank (
        .clk   (clk),
        .addr  (bank_addr),
        .we    (bank_we),
        .re    (bank_re),
        .wdata (bank_wdata),
        .rdata (bank_rdata)
    );

    always_ff @(posedge clk) begin
        if (accept) begin
            rsp_size     <= size;
            rsp_offset   <= offset;
            rsp_unsigned <= req_unsigned;
            rsp_load     <= !req_write && !fault;
        end
    end

    assign fresh_rdata = rsp_load ? load_align(merge_left(beat1_word, bank_rdata, rsp_offset),
                                               rsp_size, rsp_unsigned) : 32'h0;

    // The bank output moves on the next load, so the delivered value is kept for the hold period.
    assign resp_rdata = resp_valid ? fresh_rdata : rdata_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_valid <= 1'b0;
            resp_fault <= 1'b0;
            rdata_q    <= 32'h0;
        end else begin
            resp_valid <= respond;
            if (respond)    resp_fault <= accept && fault;
            if (resp_valid) rdata_q    <= fresh_rdata;
        end
    end

endmodule

// File: tb/tb_data_memory_unit.sv
// Randomized and directed bench for data_memory_unit, checked every cycle against a byte-array model.
`timescale 1ns/1ps
module tb_data_memory_unit;

    localparam int DEPTH     = 16;
    localparam int MEM_BYTES = 4 * DEPTH;
    localparam logic [1:0] SZ_B = 2'b00, SZ_H = 2'b01, SZ_W = 2'b10, SZ_X = 2'b11;

    logic        clk = 1'b0, rst = 1'b1;
    logic        req_valid = 1'b0, req_write = 1'b0, req_unsigned = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
    logic        req_ready, resp_valid, resp_fault;
    logic [31:0] resp_rdata;

    data_memory_unit #(.DEPTH_WORDS(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_fault   (resp_fault)
    );

    always #5 clk = ~clk;

    // Reference state: byte image, one pending response, split busy cycle, deferred beat-2 bytes.
    logic [7:0]  model_mem [MEM_BYTES];
    int          cyc = 0, n_cmp = 0, n_err = 0;
    int          due = -1, split_busy = -1;
    bit          in_rst = 1'b1;
    logic [31:0] due_rdata = 32'h0, last_rdata = 32'h0;
    logic        due_fault = 1'b0, last_fault = 1'b0;
    int          pend_n = 0;
    int          pend_addr [4];
    logic [7:0]  pend_data [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %08h, expected %08h", name, cyc, act, exp);
        end
    endtask

    task automatic compare_cycle(output bit rdy);
        bit exp_v;
        rdy   = !in_rst && (cyc != split_busy);
        exp_v = (due == cyc);
        check("req_ready", {31'h0, req_ready}, {31'h0, rdy});
        check("resp_valid", {31'h0, resp_valid}, {31'h0, exp_v});
        if (exp_v) begin
            last_rdata = due_rdata;
            last_fault = due_fault;
            due        = -1;
        end
        check("resp_rdata", resp_rdata, last_rdata);
        check("resp_fault", {31'h0, resp_fault}, {31'h0, last_fault});
    endtask

    task automatic model_accept(input logic w, input logic [1:0] sz, input logic u,
                                input logic [31:0] a, input logic [31:0] wd);
        longint      la;
        int          n;
        bit          flt, mis, spl;
        logic [31:0] v;
        la  = a;
        n   = (sz == SZ_B) ? 1 : (sz == SZ_H) ? 2 : 4;
        flt = (sz == SZ_X) || (la >= MEM_BYTES) || (la + n - 1 >= MEM_BYTES);
        mis = (sz == SZ_H && a[0]) || (sz == SZ_W && a[1:0] != 2'b00);
`ifdef DMEM_MISALIGN_SPLIT_EN
        spl = !flt && mis;
`else
        flt = flt || mis;
        spl = 1'b0;
`endif
        v = 32'h0;
        if (!flt && w) begin
            for (int i = 0; i < n; i++) begin
                if (spl && ((la + i) / 4 != la / 4)) begin
                    pend_addr[pend_n] = int'(la + i);
                    pend_data[pend_n] = 8'(wd >> (8 * (n - 1 - i)));
                    pend_n++;
                end else begin
                    model_mem[int'(la + i)] = 8'(wd >> (8 * (n - 1 - i)));
                end
            end
        end
        if (!flt && !w) begin
            for (int i = 0; i < n; i++) v = (v << 8) | 32'(model_mem[int'(la + i)]);
            if (!u && n == 1 && v[7])  v = v | 32'hFFFF_FF00;
            if (!u && n == 2 && v[15]) v = v | 32'hFFFF_0000;
        end
        due       = cyc + (spl ? 2 : 1);
        due_rdata = v;
        due_fault = flt;
        if (spl) split_busy = cyc + 1;
    endtask

    task automatic step(input logic v, input logic w, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] wd);
        bit rdy;
        @(negedge clk);
        cyc++;
        compare_cycle(rdy);
        for (int i = 0; i < pend_n; i++) model_mem[pend_addr[i]] = pend_data[i];
        pend_n       = 0;
        req_valid    = v;
        req_write    = w;
        req_size     = sz;
        req_unsigned = u;
        req_addr     = a;
        req_wdata    = wd;
        if (v && rdy) model_accept(w, sz, u, a, wd);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, SZ_B, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic pulse_reset(input int cycles);
        bit rdy;
        @(negedge clk);
        cyc++;
        compare_cycle(rdy);
        rst        = 1'b1;
        req_valid  = 1'b0;
        in_rst     = 1'b1;
        pend_n     = 0;
        due        = -1;
        split_busy = -1;
        last_rdata = 32'h0;
        last_fault = 1'b0;
        #1 compare_cycle(rdy);
        repeat (cycles) begin
            @(negedge clk);
            cyc++;
            compare_cycle(rdy);
        end
        rst    = 1'b0;
        in_rst = 1'b0;
    endtask

    task automatic lit(input string name, input logic [31:0] exp);
        check({name, "_valid"}, {31'h0, resp_valid}, 32'd1);
        check(name, resp_rdata, exp);
        check({name, "_fault"}, {31'h0, resp_fault}, 32'd0);
    endtask

    task automatic lit_fault(input string name);
        check({name, "_valid"}, {31'h0, resp_valid}, 32'd1);
        check({name, "_fault"}, {31'h0, resp_fault}, 32'd1);
        check({name, "_rdata"}, resp_rdata, 32'h0);
    endtask

    initial begin
        bit rdy;
        repeat (3) begin
            @(negedge clk);
            cyc++;
            compare_cycle(rdy);
        end
        check("reset_rdata", resp_rdata, 32'h0);
        rst    = 1'b0;
        in_rst = 1'b0;
        #1 check("ready_after_reset", {31'h0, req_ready}, 32'd1);

        for (int w = 0; w < DEPTH; w++) step(1'b1, 1'b1, SZ_W, 1'b0, 32'(w * 4), $urandom);

        step(1'b1, 1'b1, SZ_W, 1'b0, 32'h10, 32'hDEAD_BEEF);
        step(1'b1, 1'b0, SZ_B, 1'b1, 32'h10, 32'h0);
        step(1'b1, 1'b0, SZ_B, 1'b0, 32'h13, 32'h0);
        lit("lbu_10", 32'h0000_00DE);
        step(1'b1, 1'b0, SZ_H, 1'b0, 32'h12, 32'h0);
        lit("lb_13", 32'hFFFF_FFEF);
        step(1'b1, 1'b1, SZ_B, 1'b0, 32'h11, 32'h0000_005A);
        lit("lh_12", 32'hFFFF_BEEF);
        step(1'b1, 1'b0, SZ_W, 1'b0, 32'h10, 32'h0);
        idle();
        lit("lw_after_sb", 32'hDE5A_BEEF);
        step(1'b1, 1'b1, SZ_X, 1'b0, 32'h10, 32'h1234_5678);
        step(1'b1, 1'b1, SZ_W, 1'b0, 32'(MEM_BYTES), 32'h1234_5678);
        lit_fault("illegal_size");
        step(1'b1, 1'b0, SZ_W, 1'b0, 32'h10, 32'h0);
        lit_fault("addr_out_of_range");
        step(1'b1, 1'b0, SZ_W, 1'b0, 32'(MEM_BYTES - 2), 32'h0);
        lit("unchanged_after_faults", 32'hDE5A_BEEF);
        idle();
        lit_fault("last_byte_out_of_range");

        step(1'b1, 1'b1, SZ_W, 1'b0, 32'h0, 32'h0011_2233);
        step(1'b1, 1'b1, SZ_W, 1'b0, 32'h4, 32'h4455_6677);
        step(1'b1, 1'b0, SZ_W, 1'b0, 32'h2, 32'h0);
`ifdef DMEM_MISALIGN_SPLIT_EN
        idle();
        check("split_ready_low", {31'h0, req_ready}, 32'd0);
        idle();
        lit("split_load_02", 32'h2233_4455);

        step(1'b1, 1'b1, SZ_W, 1'b0, 32'h3, 32'hAABB_CCDD);
        idle();
        step(1'b1, 1'b0, SZ_W, 1'b0, 32'h0, 32'h0);
        step(1'b1, 1'b0, SZ_W, 1'b0, 32'h4, 32'h0);
        lit("split_store_w0", 32'h0011_22AA);
        idle();
        lit("split_store_w4", 32'hBBCC_DD77);

        step(1'b1, 1'b1, SZ_W, 1'b0, 32'h0, 32'h0011_2233);
        step(1'b1, 1'b1, SZ_W, 1'b0, 32'h4, 32'h4455_6677);
        step(1'b1, 1'b1, SZ_W, 1'b0, 32'h3, 32'hAABB_CCDD);
        pulse_reset(2);
        idle();
        check("ready_after_split_reset", {31'h0, req_ready}, 32'd1);
        step(1'b1, 1'b0, SZ_W, 1'b0, 32'h0, 32'h0);
        step(1'b1, 1'b0, SZ_W, 1'b0, 32'h4, 32'h0);
        lit("reset_split_w0", 32'h0011_22AA);
        idle();
        lit("reset_split_w4", 32'h4455_6677);
`else
        idle();
        lit_fault("misaligned_load_02");
        pulse_reset(2);
        idle();
        check("ready_after_reset_pulse", {31'h0, req_ready}, 32'd1);
`endif

        repeat (3000) begin
            logic [31:0] a;
            logic [1:0]  sz;
            a  = ($urandom_range(19) == 0) ? $urandom : 32'($urandom_range(MEM_BYTES + 3));
            sz = ($urandom_range(9) == 0) ? SZ_X : 2'($urandom_range(2));
            step($urandom_range(4) != 0, 1'($urandom_range(1)), sz, 1'($urandom_range(1)),
                 a, $urandom);
        end
        repeat (4) idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
